alu_operand_stage: RTL
======================

// Module: alu_operand_stage
// PURPOSE
// Operand-fetch/issue stage directly upstream of the 8-bit ALU. Latches one decoded
// instruction per cycle, reads register-file operands, forwards the ALU's registered
// result and load-return data, and tracks outstanding loads in a per-register scoreboard.
// Drives the ALU's op/in_a/in_b and generates the data_hazard stall seen by the ALU and decoder.
// PARAMETERS
// AW  3  register address width (2**AW registers)
// DW  8  data width; must equal ALU width
// PORTS
// clk          in   1   system clock, all state on posedge
// rst          in   1   synchronous reset, active-high
// dec_valid    in   1   decoder presents an instruction
// dec_ready    out  1   stage accepts instruction this cycle (= ~data_hazard)
// dec_op       in   3   ALU op code (000 pass A .. 111 xor, 001 sets OVF)
// dec_sa       in   AW  source A register
// dec_sb       in   AW  source B register (ignored when dec_b_imm=1)
// dec_b_imm    in   1   in_b taken from dec_imm
// dec_imm      in   DW  immediate operand
// dec_dst      in   AW  destination register
// dec_we       in   1   ALU result written to dec_dst
// dec_ld       in   1   dec_dst will be written by an external load (marks scoreboard)
// rf_addr_a    out  AW  RF read address A (= S1 sa)
// rf_addr_b    out  AW  RF read address B (= S1 sb)
// rf_data_a    in   DW  RF async read data A
// rf_data_b    in   DW  RF async read data B
// alu_result   in   DW  ALU registered output (alu_out)
// ld_done      in   1   load return strobe, one cycle
// ld_dst       in   AW  load return register
// ld_data      in   DW  load return data
// op           out  3   to ALU op
// in_a, in_b   out  DW  to ALU operands
// data_hazard  out  1   stall to ALU and decoder
// ex_dst       out  AW  destination of instruction currently held in ALU
// ex_we        out  1   ALU result at alu_result is to be written to ex_dst
// BEHAVIOUR
// - Reset: S1 valid=0, pend[*]=0, ex_we=0, ex_dst=0, data_hazard=0, op=000, in_a=in_b=0.
// - Pipeline: instr accepted at edge E into S1; operands driven combinationally during
//   following cycle; ALU captures at edge E+1; result on alu_result after E+1.
// - S1 load: on posedge, if ~data_hazard: s1 <= dec_valid ? dec fields : bubble.
//   If data_hazard: S1, ex_dst, ex_we hold (ALU also holds alu_reg, forwarding stays valid).
// - ex tracking: if ~data_hazard: ex_dst<=s1.dst, ex_we<=s1.valid & s1.we & ~s1.ld.
// - Operand mux per source (priority): ex_we & ex_dst==src -> alu_result;
//   ld_done & ld_dst==src -> ld_data; else rf_data. B uses dec_imm when b_imm, never hazards.
// - Hazard: data_hazard = s1.valid & ((pend[sa] & ~(ld_done & ld_dst==sa)) |
//   (~b_imm & pend[sb] & ~(ld_done & ld_dst==sb))). Combinational; no latency.
// - Bubble (S1 invalid): op=000, in_a=in_b=0, data_hazard=0; OVF unaffected.
// - Scoreboard: pend[ld_dst] cleared on ld_done; pend[s1.dst] set when s1.valid & s1.ld &
//   ~data_hazard. Same register set and cleared same cycle -> set wins.
// - Load to a reg with pend already set: no stall (WAW not tracked); first ld_done clears.
// - ld_done for register with pend=0: ignored, no error.
// - Reset mid-stall: drops S1 and all pending marks; late ld_done after reset has no effect on state.
// TESTING
// 1 Reset: assert rst 2 cycles with dec_valid=1 -> op=000, in_a=in_b=0, data_hazard=0, ex_we=0.
// 2 Back-to-back: ADD r1<=r2+r3 (RF r2=0x10,r3=0x05) then XOR r4<=r1^imm 0xFF -> ALU sees
//   in_a=0x15 (forwarded), alu_result=0xEA two edges later, no stall.
// 3 Load stall: LD r5 issued, next instr reads r5 -> data_hazard=1, dec_ready=0 held until
//   ld_done(r5, 0x3C); that cycle in_a=0x3C, hazard=0, instr issues once.
// 4 Immediate bypass: pend[r6]=1, instr b_imm=1 sb=r6, sa=r0 -> no stall, in_b=dec_imm.
// 5 Set/clear collision: ld_done(r2) same cycle a new LD r2 issues -> pend[r2]=1 afterwards.
// 6 Reset during stall: hazard on pend[r5], assert rst -> data_hazard=0, pend all 0, S1 empty.

Source files
------------

// File: rtl/alu_operand_stage.sv
// Operand-fetch/issue stage feeding the 8-bit ALU: latches one decoded instruction,
// forwards ALU and load-return data, and stalls on registers with loads outstanding.
module alu_operand_stage #(
    parameter int unsigned AW = 3,
    parameter int unsigned DW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          dec_valid,
    output logic          dec_ready,
    input  logic [2:0]    dec_op,
    input  logic [AW-1:0] dec_sa,
    input  logic [AW-1:0] dec_sb,
    input  logic          dec_b_imm,
    input  logic [DW-1:0] dec_imm,
    input  logic [AW-1:0] dec_dst,
    input  logic          dec_we,
    input  logic          dec_ld,
    output logic [AW-1:0] rf_addr_a,
    output logic [AW-1:0] rf_addr_b,
    input  logic [DW-1:0] rf_data_a,
    input  logic [DW-1:0] rf_data_b,
    input  logic [DW-1:0] alu_result,
    input  logic          ld_done,
    input  logic [AW-1:0] ld_dst,
    input  logic [DW-1:0] ld_data,
    output logic [2:0]    op,
    output logic [DW-1:0] in_a,
    output logic [DW-1:0] in_b,
    output logic          data_hazard,
    output logic [AW-1:0] ex_dst,
    output logic          ex_we
);

    localparam int unsigned NREG = 1 << AW;

    typedef struct packed {
        logic          valid;
        logic [2:0]    op;
        logic [AW-1:0] sa;
        logic [AW-1:0] sb;
        logic          b_imm;
        logic [DW-1:0] imm;
        logic [AW-1:0] dst;
        logic          we;
        logic          ld;
    } s1_t;

    s1_t             s1_q, s1_d;
    logic [AW-1:0]   ex_dst_q, ex_dst_d;
    logic            ex_we_q, ex_we_d;
    logic [NREG-1:0] pend_q, pend_d;

    logic            ld_hit_a, ld_hit_b;
    logic            haz_a, haz_b;
    logic [DW-1:0]   fwd_a, fwd_b;

    // A load returning this very cycle resolves its own hazard.
    always_comb begin
        ld_hit_a    = ld_done && (ld_dst == s1_q.sa);
        ld_hit_b    = ld_done && (ld_dst == s1_q.sb);
        haz_a       = pend_q[s1_q.sa] && !ld_hit_a;
        haz_b       = !s1_q.b_imm && pend_q[s1_q.sb] && !ld_hit_b;
        data_hazard = s1_q.valid && (haz_a || haz_b);
    end

    always_comb begin
        if (ex_we_q && (ex_dst_q == s1_q.sa)) begin
            fwd_a = alu_result;
        end else if (ld_hit_a) begin
            fwd_a = ld_data;
        end else begin
            fwd_a = rf_data_a;
        end

        if (s1_q.b_imm) begin
            fwd_b = s1_q.imm;
        end else if (ex_we_q && (ex_dst_q == s1_q.sb)) begin
            fwd_b = alu_result;
        end else if (ld_hit_b) begin
            fwd_b = ld_data;
        end else begin
            fwd_b = rf_data_b;
        end
    end

    always_comb begin
        op   = '0;
        in_a = '0;
        in_b = '0;
        if (s1_q.valid) begin
            op   = s1_q.op;
            in_a = fwd_a;
            in_b = fwd_b;
        end
    end

    always_comb begin
        s1_d     = s1_q;
        ex_dst_d = ex_dst_q;
        ex_we_d  = ex_we_q;
        if (!data_hazard) begin
            if (dec_valid) begin
                s1_d.valid = 1'b1;
                s1_d.op    = dec_op;
                s1_d.sa    = dec_sa;
                s1_d.sb    = dec_sb;
                s1_d.b_imm = dec_b_imm;
                s1_d.imm   = dec_imm;
                s1_d.dst   = dec_dst;
                s1_d.we    = dec_we;
                s1_d.ld    = dec_ld;
            end else begin
                s1_d = '0;
            end
            ex_dst_d = s1_q.dst;
            ex_we_d  = s1_q.valid && s1_q.we && !s1_q.ld;
        end
    end

    // Set is applied after clear so a same-cycle set/clear on one register leaves it pending.
    always_comb begin
        pend_d = pend_q;
        if (ld_done) begin
            pend_d[ld_dst] = 1'b0;
        end
        if (s1_q.valid && s1_q.ld && !data_hazard) begin
            pend_d[s1_q.dst] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_q     <= '0;
            ex_dst_q <= '0;
            ex_we_q  <= 1'b0;
            pend_q   <= '0;
        end else begin
            s1_q     <= s1_d;
            ex_dst_q <= ex_dst_d;
            ex_we_q  <= ex_we_d;
            pend_q   <= pend_d;
        end
    end

    assign dec_ready = !data_hazard;
    assign rf_addr_a = s1_q.sa;
    assign rf_addr_b = s1_q.sb;
    assign ex_dst    = ex_dst_q;
    assign ex_we     = ex_we_q;

endmodule
